// File: rtl/t_pass_mon.sv
// Result monitor: qualifies the per-subtest passedv vector into a sticky PASS/FAIL verdict.
// Optional simulation messages and $finish/$stop on verdict entry: define T_PASS_MON_DISPLAY_EN.
module t_pass_mon #(
  parameter int NUM_TESTS      = 21,
  parameter int IDX_W          = 5,
  parameter int SETTLE_CYCLES  = 4,
  parameter int STABLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic [NUM_TESTS-1:0] passedv,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic [1:0]           fail_code,
  output logic [IDX_W-1:0]     fail_idx,
  output logic [CNT_W-1:0]     cycles
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int STB_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST  = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [STB_W-1:0] STABLE_DONE  = STB_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  typedef enum logic [2:0] {S_SETTLE, S_WAIT, S_STABLE, S_PASS, S_FAIL} state_t;

  state_t               state_q, state_d;
  logic [SET_W-1:0]     settle_q, settle_d;
  logic [STB_W-1:0]     stable_q, stable_d, stableNext;
  logic [NUM_TESTS-1:0] seen_q, seen_d, drop, allSeen;
  logic [CNT_W-1:0]     cycles_q, cycles_d;
  logic                 done_q, done_d, pass_q, pass_d, fail_q, fail_d;
  logic [1:0]           code_q, code_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  function automatic logic [IDX_W-1:0] lowestIdx(input logic [NUM_TESTS-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_TESTS - 1; i >= 0; i--) begin
      if (m[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q  <= S_SETTLE;
      settle_q <= '0;
      stable_q <= '0;
      seen_q   <= '0;
      cycles_q <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      code_q   <= 2'd0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      stable_q <= stable_d;
      seen_q   <= seen_d;
      cycles_q <= cycles_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      code_q   <= code_d;
      idx_q    <= idx_d;
    end
  end

  // drop uses the mask as it stood before this sample; priority is DROP > PASS > TIMEOUT.
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    stable_d   = stable_q;
    seen_d     = seen_q;
    cycles_d   = cycles_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    code_d     = code_q;
    idx_d      = idx_q;
    drop       = seen_q & ~passedv;
    allSeen    = seen_q | passedv;
    stableNext = (state_q == S_WAIT) ? STB_W'(1) : stable_q + STB_W'(1);

    case (state_q)
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = S_WAIT;
        else                         settle_d = settle_q + SET_W'(1);
      end
      S_WAIT, S_STABLE: begin
        seen_d   = allSeen;
        cycles_d = (cycles_q == CNT_MAX) ? cycles_q : cycles_q + CNT_W'(1);
        if (drop != '0) begin
          state_d = S_FAIL;
          done_d  = 1'b1;
          fail_d  = 1'b1;
          code_d  = 2'd1;
          idx_d   = lowestIdx(drop);
        end else if ((&passedv) && (stableNext == STABLE_DONE)) begin
          state_d = S_PASS;
          done_d  = 1'b1;
          pass_d  = 1'b1;
        end else if (cycles_q == TIMEOUT_LAST) begin
          state_d = S_FAIL;
          done_d  = 1'b1;
          fail_d  = 1'b1;
          code_d  = 2'd2;
          idx_d   = (~allSeen != '0) ? lowestIdx(~allSeen) : lowestIdx(~passedv);
        end else if (&passedv) begin
          state_d  = S_STABLE;
          stable_d = stableNext;
        end
      end
      S_PASS, S_FAIL: ;
      default: state_d = S_SETTLE;
    endcase
  end

`ifdef T_PASS_MON_DISPLAY_EN
  always_ff @(posedge clk) begin
    if (reset_l) begin
      if (state_q != S_PASS && state_d == S_PASS) begin
        $display("*-* All Finished *-* cycles=%0d", cycles_d);
        $finish;
      end
      if (state_q != S_FAIL && state_d == S_FAIL) begin
        $display("t_pass_mon verdict FAIL code=%0d idx=%0d cycles=%0d", code_d, idx_d, cycles_d);
        $stop;
      end
    end
  end
`endif

  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign fail_code = code_q;
  assign fail_idx  = idx_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_t_pass_mon.sv
// Testbench for t_pass_mon: two instances (default and short timeout/stable) share stimulus
// and are compared each cycle against a history-based reference model.
module tb_t_pass_mon;

  localparam int SETTLE = 4;

  typedef struct packed {
    logic        done;
    logic        pass;
    logic        fail;
    logic [1:0]  code;
    logic [4:0]  idx;
    logic [15:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_l;
  logic [20:0] passedv;
  logic        done1, pass1, fail1, done2, pass2, fail2;
  logic [1:0]  code1, code2;
  logic [4:0]  idx1, idx2;
  logic [15:0] cyc1, cyc2;

  logic [20:0] hist[$];
  int          edges;
  int          checkCount = 0;
  int          passCount  = 0;
  int          failCount  = 0;

  t_pass_mon dut (
    .clk(clk), .reset_l(reset_l), .passedv(passedv),
    .done(done1), .pass(pass1), .fail(fail1),
    .fail_code(code1), .fail_idx(idx1), .cycles(cyc1)
  );

  t_pass_mon #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(10)) dut2 (
    .clk(clk), .reset_l(reset_l), .passedv(passedv),
    .done(done2), .pass(pass2), .fail(fail2),
    .fail_code(code2), .fail_idx(idx2), .cycles(cyc2)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] lowestBit(input logic [20:0] m);
    for (int i = 0; i < 21; i++) if (m[i]) return 5'(i);
    return 5'd0;
  endfunction

  // Verdict derived by scanning the whole sampled history with the monitor's rules.
  function automatic exp_t model(input int stN, input int toN);
    exp_t        e;
    logic [20:0] seen, s;
    int          run;
    e = '0;
    seen = '0;
    run = 0;
    for (int k = 0; k < hist.size(); k++) begin
      if (e.done) break;
      s = hist[k];
      if (e.cyc != 16'hFFFF) e.cyc = e.cyc + 16'd1;
      run = (&s) ? run + 1 : 0;
      if ((seen & ~s) != 21'd0) begin
        e.done = 1'b1; e.fail = 1'b1; e.code = 2'd1; e.idx = lowestBit(seen & ~s);
      end else if (run >= stN) begin
        e.done = 1'b1; e.pass = 1'b1;
      end else if (k + 1 == toN) begin
        e.done = 1'b1; e.fail = 1'b1; e.code = 2'd2;
        e.idx = (~(seen | s) != 21'd0) ? lowestBit(~(seen | s)) : lowestBit(~s);
      end
      seen = seen | s;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e1, e2;
    e1 = model(8, 1000);
    e2 = model(4, 10);
    check("dut.done", 32'(done1), 32'(e1.done));
    check("dut.pass", 32'(pass1), 32'(e1.pass));
    check("dut.fail", 32'(fail1), 32'(e1.fail));
    check("dut.fail_code", 32'(code1), 32'(e1.code));
    check("dut.fail_idx", 32'(idx1), 32'(e1.idx));
    check("dut.cycles", 32'(cyc1), 32'(e1.cyc));
    check("dut2.done", 32'(done2), 32'(e2.done));
    check("dut2.pass", 32'(pass2), 32'(e2.pass));
    check("dut2.fail", 32'(fail2), 32'(e2.fail));
    check("dut2.fail_code", 32'(code2), 32'(e2.code));
    check("dut2.fail_idx", 32'(idx2), 32'(e2.idx));
    check("dut2.cycles", 32'(cyc2), 32'(e2.cyc));
  endtask

  task automatic applyStimulus(input logic [20:0] v);
    passedv = v;
    @(posedge clk);
    if (edges >= SETTLE) hist.push_back(v);
    edges++;
    #1;
    checkOutput();
  endtask

  task automatic applyReset(input int n);
    reset_l = 1'b0;
    hist.delete();
    edges = 0;
    repeat (n) @(posedge clk);
    #1;
    reset_l = 1'b1;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".outputs1"}, {22'd0, done1, pass1, fail1, code1, idx1}, 32'd0);
    check({tag, ".cycles1"}, 32'(cyc1), 32'd0);
    check({tag, ".outputs2"}, {22'd0, done2, pass2, fail2, code2, idx2}, 32'd0);
    check({tag, ".cycles2"}, 32'(cyc2), 32'd0);
  endtask

  initial begin
    int          riseAt[21];
    int          dropIdx, dropAt;
    logic [20:0] v;

    passedv = '0;
    edges   = 0;
    applyReset(3);
    checkAllZero("reset");

    // All-ones from the start: settle ignored, PASS after 8 samples.
    repeat (SETTLE + 8) applyStimulus('1);
    check("allones.pass", 32'(pass1), 32'd1);
    check("allones.cycles", 32'(cyc1), 32'd8);
    repeat (4) applyStimulus(21'($urandom));
    check("allones.sticky", 32'({done1, pass1, fail1}), 32'b110);

    // Reset pulse after PASS clears outputs before the next edge.
    reset_l = 1'b0;
    #1;
    checkAllZero("midreset");
    hist.delete();
    edges = 0;
    @(posedge clk);
    #1;
    reset_l = 1'b1;
    repeat (SETTLE) applyStimulus('1);
    check("resettle.cycles", 32'(cyc1), 32'd0);
    repeat (8) applyStimulus('1);
    check("resettle.pass", 32'({done1, pass1, cyc1}), {14'd0, 2'b11, 16'd8});

    // Bit 3 rises at sample 2, falls at sample 5.
    applyReset(2);
    repeat (SETTLE) applyStimulus('0);
    for (int k = 1; k <= 5; k++) applyStimulus((k >= 2 && k <= 4) ? 21'h8 : 21'h0);
    check("drop3.verdict", 32'({fail1, code1, idx1, cyc1}), {8'd0, 1'b1, 2'd1, 5'd3, 16'd5});
    repeat (5) applyStimulus(21'($urandom));
    check("drop3.done", 32'(done1), 32'd1);

    // Bit 20 never passes: timeout on sample 1000.
    applyReset(2);
    repeat (SETTLE + 1002) applyStimulus(21'h0F_FFFF);
    check("timeout.verdict", 32'({fail1, code1, idx1}), {24'd0, 1'b1, 2'd2, 5'd20});
    check("timeout.cycles", 32'(cyc1), 32'd1000);

    // Bit 0 drops for one sample after 5 all-ones samples.
    applyReset(2);
    repeat (SETTLE + 5) applyStimulus('1);
    applyStimulus(21'h1F_FFFE);
    repeat (6) applyStimulus('1);
    check("drop0.verdict", 32'({pass1, fail1, code1, idx1, cyc1}), {8'd0, 2'b01, 2'd1, 5'd0, 16'd6});

    // Short-timeout instance: PASS completes on the timeout sample and wins.
    applyReset(2);
    repeat (SETTLE + 6) applyStimulus('0);
    repeat (6) applyStimulus('1);
    check("passvstimeout.verdict", 32'({pass2, fail2, code2}), 32'b1000);
    check("passvstimeout.cycles", 32'(cyc2), 32'd10);

    // Randomized rise times with an occasional single-sample drop; settle fed junk.
    for (int sc = 0; sc < 12; sc++) begin
      applyReset(1);
      for (int i = 0; i < 21; i++) riseAt[i] = $urandom_range(1, 10);
      dropIdx = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, 20);
      dropAt  = (dropIdx >= 0) ? riseAt[dropIdx] + $urandom_range(0, 6) : 0;
      repeat (SETTLE) applyStimulus(21'($urandom));
      for (int k = 1; k <= 24; k++) begin
        for (int i = 0; i < 21; i++) v[i] = (k >= riseAt[i]) && !(i == dropIdx && k == dropAt);
        applyStimulus(v);
      end
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
